// File: rtl/alu_divider_if.sv
// Handshake and result bundle between the control unit and the sequential divider.
// The master issues operands with a start pulse; the slave returns registered results.
interface alu_divider_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             half_mode;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             z;
   logic             div_zero;
   logic             busy;
   logic             done;

   modport master (
      output start, a, b, half_mode,
      input  quotient, remainder, z, div_zero, busy, done
   );

   modport slave (
      input  start, a, b, half_mode,
      output quotient, remainder, z, div_zero, busy, done
   );
endinterface

// File: rtl/alu_divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock, with an
// 8-bit half mode whose results are zero-extended to the full width.
module alu_divider #(
   parameter int unsigned WIDTH = 16
) (
   input logic         clk,
   input logic         rst_n,
   alu_divider_if.slave bus
);
   localparam int unsigned HW   = WIDTH / 2;
   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastFull = CntW'(WIDTH - 1);
   localparam logic [CntW-1:0] LastHalf = CntW'(HW - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] quo_sh_q, quo_sh_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             half_q, half_d;

   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             z_q, z_d;
   logic             div_zero_q, div_zero_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] a_eff, b_eff, a_left, ones_eff;
   logic [WIDTH:0]   part_shift;
   logic             ge;
   logic [WIDTH-1:0] part_next, quo_next;
   logic [CntW-1:0]  cnt_last;

   always_comb begin
      a_eff    = bus.half_mode ? {{HW{1'b0}}, bus.a[HW-1:0]} : bus.a;
      b_eff    = bus.half_mode ? {{HW{1'b0}}, bus.b[HW-1:0]} : bus.b;
      // Half-mode dividend sits in the top byte so the MSB tap is the same in both modes.
      a_left   = bus.half_mode ? {bus.a[HW-1:0], {HW{1'b0}}} : bus.a;
      ones_eff = bus.half_mode ? {{HW{1'b0}}, {HW{1'b1}}} : {WIDTH{1'b1}};

      part_shift = {part_q, dvd_q[WIDTH-1]};
      ge         = part_shift >= {1'b0, dvs_q};
      // The restored partial is always below the divisor, so truncation is lossless.
      part_next  = ge ? (part_shift[WIDTH-1:0] - dvs_q) : part_shift[WIDTH-1:0];
      quo_next   = (quo_sh_q << 1) | WIDTH'(ge);
      cnt_last   = half_q ? LastHalf : LastFull;

      state_d     = state_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      part_d      = part_q;
      quo_sh_d    = quo_sh_q;
      cnt_d       = cnt_q;
      half_d      = half_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      z_d         = z_q;
      div_zero_d  = div_zero_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               half_d = bus.half_mode;
               dvs_d  = b_eff;
               if (b_eff == '0) begin
                  quotient_d  = ones_eff;
                  remainder_d = a_eff;
                  z_d         = 1'b0;
                  div_zero_d  = 1'b1;
                  state_d     = StDone;
               end else begin
                  dvd_d    = a_left;
                  part_d   = '0;
                  quo_sh_d = '0;
                  cnt_d    = '0;
                  state_d  = StRun;
               end
            end
         end
         StRun: begin
            dvd_d    = dvd_q << 1;
            part_d   = part_next;
            quo_sh_d = quo_next;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == cnt_last) begin
               quotient_d  = quo_next;
               remainder_d = part_next;
               z_d         = (quo_next == '0);
               div_zero_d  = 1'b0;
               state_d     = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         dvd_q       <= '0;
         dvs_q       <= '0;
         part_q      <= '0;
         quo_sh_q    <= '0;
         cnt_q       <= '0;
         half_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         z_q         <= 1'b0;
         div_zero_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         part_q      <= part_d;
         quo_sh_q    <= quo_sh_d;
         cnt_q       <= cnt_d;
         half_q      <= half_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         z_q         <= z_d;
         div_zero_q  <= div_zero_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.z         = z_q;
   assign bus.div_zero  = div_zero_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_alu_divider.sv
// Directed bench for alu_divider: latency, results, flags, ignored starts and async reset.
module tb_alu_divider;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_divider_if #(.WIDTH(16)) bus ();

   alu_divider #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns at the negedge after the accepting edge E0.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic h);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.a         = a;
      bus.b         = b;
      bus.half_mode = h;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Extra negedges waited until done is seen; bounded so a stuck DUT shows as bad latency.
   task automatic wait_done(output int n);
      n = 0;
      while (bus.done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.quotient !== 16'h0 || bus.remainder !== 16'h0) begin
         errors++;
         $display("FAIL reset_results got q=%h r=%h exp 0/0", bus.quotient, bus.remainder);
      end
      checks++;
      if ({bus.z, bus.div_zero, bus.busy, bus.done} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 0000", {bus.z, bus.div_zero, bus.busy, bus.done});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      int n;
      issue(16'd100, 16'd7, 1'b0);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_rise got %b exp 1", bus.busy);
      end
      wait_done(n);
      checks++;
      if (n + 1 !== 17) begin
         errors++;
         $display("FAIL basic_latency got %0d exp 17", n + 1);
      end
      checks++;
      if (bus.quotient !== 16'd14 || bus.remainder !== 16'd2) begin
         errors++;
         $display("FAIL basic_result got q=%0d r=%0d exp 14/2", bus.quotient, bus.remainder);
      end
      checks++;
      if (bus.z !== 1'b0 || bus.div_zero !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_flags got z=%b dz=%b busy=%b exp 0/0/1", bus.z, bus.div_zero,
                  bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== 16'd14) begin
         errors++;
         $display("FAIL basic_after got done=%b busy=%b q=%0d exp 0/0/14", bus.done, bus.busy,
                  bus.quotient);
      end
   endtask

   task automatic test_half;
      int n;
      issue(16'h12FF, 16'hAB10, 1'b1);
      wait_done(n);
      checks++;
      if (n + 1 !== 9) begin
         errors++;
         $display("FAIL half_latency got %0d exp 9", n + 1);
      end
      checks++;
      if (bus.quotient !== 16'h000F || bus.remainder !== 16'h000F) begin
         errors++;
         $display("FAIL half_result got q=%h r=%h exp 000f/000f", bus.quotient, bus.remainder);
      end
   endtask

   task automatic test_div_zero;
      int n;
      issue(16'h1234, 16'h0000, 1'b0);
      wait_done(n);
      checks++;
      if (n + 1 !== 1) begin
         errors++;
         $display("FAIL dz_latency got %0d exp 1", n + 1);
      end
      checks++;
      if (bus.quotient !== 16'hFFFF || bus.remainder !== 16'h1234 || bus.div_zero !== 1'b1 ||
          bus.z !== 1'b0) begin
         errors++;
         $display("FAIL dz_full got q=%h r=%h dz=%b z=%b exp ffff/1234/1/0", bus.quotient,
                  bus.remainder, bus.div_zero, bus.z);
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL dz_busy_fall got busy=%b done=%b exp 0/0", bus.busy, bus.done);
      end
      issue(16'h1234, 16'h0100, 1'b1);
      wait_done(n);
      checks++;
      if (n + 1 !== 1 || bus.quotient !== 16'h00FF || bus.remainder !== 16'h0034 ||
          bus.div_zero !== 1'b1) begin
         errors++;
         $display("FAIL dz_half got lat=%0d q=%h r=%h dz=%b exp 1/00ff/0034/1", n + 1,
                  bus.quotient, bus.remainder, bus.div_zero);
      end
   endtask

   task automatic test_edges;
      int n;
      issue(16'd5, 16'd9, 1'b0);
      wait_done(n);
      checks++;
      if (bus.quotient !== 16'd0 || bus.remainder !== 16'd5 || bus.z !== 1'b1 ||
          bus.div_zero !== 1'b0) begin
         errors++;
         $display("FAIL small_over_large got q=%0d r=%0d z=%b dz=%b exp 0/5/1/0", bus.quotient,
                  bus.remainder, bus.z, bus.div_zero);
      end
      issue(16'hFFFF, 16'd1, 1'b0);
      wait_done(n);
      checks++;
      if (n + 1 !== 17 || bus.quotient !== 16'hFFFF || bus.remainder !== 16'h0 ||
          bus.z !== 1'b0) begin
         errors++;
         $display("FAIL max_by_one got lat=%0d q=%h r=%h z=%b exp 17/ffff/0000/0", n + 1,
                  bus.quotient, bus.remainder, bus.z);
      end
   endtask

   task automatic test_ignored_start;
      int n;
      int extra;
      issue(16'd100, 16'd7, 1'b0);
      // Mid-RUN start with different operands, plus operand churn.
      bus.start     = 1'b1;
      bus.a         = 16'hFFFF;
      bus.b         = 16'd1;
      bus.half_mode = 1'b1;
      repeat (3) @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 16'h0000;
      bus.b     = 16'h0000;
      wait_done(n);
      checks++;
      if (n + 4 !== 17 || bus.quotient !== 16'd14 || bus.remainder !== 16'd2) begin
         errors++;
         $display("FAIL ign_run got lat=%0d q=%0d r=%0d exp 17/14/2", n + 4, bus.quotient,
                  bus.remainder);
      end
      // Start presented while in DONE must not launch another operation.
      bus.start     = 1'b1;
      bus.a         = 16'd5;
      bus.b         = 16'd9;
      bus.half_mode = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra++;
         @(negedge clk);
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL ign_done got %0d busy/done cycles exp 0", extra);
      end
      checks++;
      if (bus.quotient !== 16'd14 || bus.remainder !== 16'd2) begin
         errors++;
         $display("FAIL ign_hold got q=%0d r=%0d exp 14/2", bus.quotient, bus.remainder);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      issue(16'd100, 16'd7, 1'b0);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.quotient !== 16'h0 || bus.remainder !== 16'h0 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got q=%h r=%h busy=%b done=%b exp 0/0/0/0", bus.quotient,
                  bus.remainder, bus.busy, bus.done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_idle got busy=%b done=%b exp 0/0", bus.busy, bus.done);
      end
      issue(16'd100, 16'd7, 1'b0);
      wait_done(n);
      checks++;
      if (n + 1 !== 17 || bus.quotient !== 16'd14 || bus.remainder !== 16'd2) begin
         errors++;
         $display("FAIL after_reset got lat=%0d q=%0d r=%0d exp 17/14/2", n + 1, bus.quotient,
                  bus.remainder);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.a         = 16'h0;
      bus.b         = 16'h0;
      bus.half_mode = 1'b0;
      test_reset;
      test_basic;
      test_half;
      test_div_zero;
      test_edges;
      test_ignored_start;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
